// File: rtl/io_map_pkg.sv
// Shared IO address map, data width and debounce defaults for the LED/switch responder.
package io_map_pkg;

   localparam logic [31:0] IO_LED_ADDR      = 32'hFFFF_FC60;
   localparam logic [31:0] IO_SW_ADDR       = 32'hFFFF_FC62;
   localparam int unsigned IO_DATA_W        = 16;
   localparam int unsigned DEF_TICK_DIV     = 50000;
   localparam int unsigned DEF_STABLE_TICKS = 20;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_LED,
      RD_SW
   } rd_src_e;

   // Both chip selects at once is an illegal decode and selects nothing.
   function automatic rd_src_e f_rd_src(input logic rd, input logic led_cs, input logic sw_cs);
      if (!rd || (led_cs && sw_cs)) return RD_NONE;
      if (sw_cs)                    return RD_SW;
      if (led_cs)                   return RD_LED;
      return RD_NONE;
   endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, saturating stability counter and debounced flop.
module switch_debounce_bit
   import io_map_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic db,
   output logic changed
);

   localparam int unsigned          CNT_W    = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_db;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differ;
   logic             w_update;

   assign w_differ = r_s2 ^ r_db;
   assign w_update = tick & w_differ & (r_cnt >= CNT_LAST);
   assign db       = r_db;
   assign changed  = w_update;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
         if (tick) begin
            if (!w_differ) begin
               r_cnt <= '0;
            end else if (w_update) begin
               r_db  <= r_s2;
               r_cnt <= '0;
            end else if (r_cnt != '1) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/io_led_switch_responder.sv
// CPU-side responder for the LED and switch chip selects: LED register, debounced switches, read mux.
module io_led_switch_responder
   import io_map_pkg::*;
#(
   parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int unsigned SW_W         = IO_DATA_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ioRead,
   input  logic            ioWrite,
   input  logic            LEDCtrl,
   input  logic            SwitchCtrl,
   input  logic [31:0]     io_wdata,
   output logic [SW_W-1:0] io_rdata,
   input  logic [SW_W-1:0] switch_in,
   output logic [SW_W-1:0] led_out,
   output logic            sw_event
);

   localparam int unsigned      PS_W    = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);

   logic [PS_W-1:0] r_ps;
   logic            w_tick;
   logic [SW_W-1:0] r_led;
   logic            r_sw_event;
   logic [SW_W-1:0] w_sw_db;
   logic [SW_W-1:0] w_changed;
   logic            w_led_wr;
   logic            w_unused;

   assign w_tick   = (r_ps == PS_LAST);
   assign w_led_wr = ioWrite && LEDCtrl && !SwitchCtrl;
   assign w_unused = ^io_wdata[31:SW_W];
   assign led_out  = r_led;
   assign sw_event = r_sw_event;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ps       <= '0;
         r_led      <= '0;
         r_sw_event <= 1'b0;
      end else begin
         r_ps       <= w_tick ? '0 : r_ps + 1'b1;
         r_sw_event <= |w_changed;
         if (w_led_wr) r_led <= io_wdata[SW_W-1:0];
      end
   end

   for (genvar g = 0; g < SW_W; g++) begin : g_db
      switch_debounce_bit #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .tick   (w_tick),
         .raw    (switch_in[g]),
         .db     (w_sw_db[g]),
         .changed(w_changed[g])
      );
   end

   // Read straight from the registers so a same-cycle LED write returns the old value.
   always_comb begin
      io_rdata = '0;
      unique case (f_rd_src(ioRead, LEDCtrl, SwitchCtrl))
         RD_SW:   io_rdata = w_sw_db;
         RD_LED:  io_rdata = r_led;
         default: io_rdata = '0;
      endcase
   end

endmodule
